// File: rtl/duck_hunt_pkg.sv
// rtl/duck_hunt_pkg.sv - shared FSM type, bird shape table and constants for sprite_frame_engine
package duck_hunt_pkg;

  localparam int BIRD_PIXELS = 13;
  localparam int WRAP_X = 5;
  localparam logic [2:0] LFSR_SEED = 3'b110;

  typedef enum logic [2:0] {IDLE, ERASE, MOVE, DRAW, DONE} state_t;

  typedef struct packed {
    logic signed [3:0] dx;
    logic signed [3:0] dy;
  } offset_t;

  // Head at (0,0), beak below it, body trailing left, wings fanning out from the body.
  function automatic offset_t bird_offset(input logic [3:0] p);
    offset_t o;
    case (p)
      4'd0:    o = '{dx:  4'sd0, dy:  4'sd0};
      4'd1:    o = '{dx:  4'sd0, dy:  4'sd1};
      4'd2:    o = '{dx: -4'sd1, dy:  4'sd0};
      4'd3:    o = '{dx: -4'sd2, dy:  4'sd0};
      4'd4:    o = '{dx: -4'sd3, dy:  4'sd0};
      4'd5:    o = '{dx: -4'sd4, dy:  4'sd0};
      4'd6:    o = '{dx: -4'sd5, dy:  4'sd0};
      4'd7:    o = '{dx: -4'sd3, dy:  4'sd1};
      4'd8:    o = '{dx: -4'sd3, dy: -4'sd1};
      4'd9:    o = '{dx: -4'sd4, dy:  4'sd2};
      4'd10:   o = '{dx: -4'sd4, dy: -4'sd2};
      4'd11:   o = '{dx: -4'sd5, dy:  4'sd3};
      4'd12:   o = '{dx: -4'sd5, dy: -4'sd3};
      default: o = '{dx:  4'sd0, dy:  4'sd0};
    endcase
    return o;
  endfunction

endpackage

// File: rtl/sprite_frame_engine_if.sv
// rtl/sprite_frame_engine_if.sv - pixel write stream from sprite_frame_engine into vga_adapter
interface sprite_frame_engine_if #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3
);
  logic [X_W-1:0]      x_out;
  logic [Y_W-1:0]      y_out;
  logic [COLOUR_W-1:0] colour;
  logic                plot;

  modport master (output x_out, y_out, colour, plot);
  modport slave  (input  x_out, y_out, colour, plot);
endinterface

// File: rtl/sprite_lfsr.sv
// rtl/sprite_lfsr.sv - 3-bit respawn-row LFSR; next_value is the state after the pending step
module sprite_lfsr
  import duck_hunt_pkg::*;
(
  input  logic       clock,
  input  logic       resetn,
  input  logic       step,
  output logic [2:0] next_value
);
  logic [2:0] s_q;
  logic       n2, n1, n0;

  assign n2 = s_q[2] ^ s_q[0];
  assign n1 = s_q[1] ^ n2;
  assign n0 = s_q[0] ^ n1;
  assign next_value = {n2, n1, n0};

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      s_q <= LFSR_SEED;
    end else if (step) begin
      s_q <= next_value;
    end
  end
endmodule

// File: rtl/sprite_frame_engine.sv
// rtl/sprite_frame_engine.sv - per-frame bird erase/move/draw pixel generator
// Optional shot/hit detection is built when HIT_DETECT_EN is defined.
module sprite_frame_engine
  import duck_hunt_pkg::*;
#(
  parameter int                  NUM_SPRITES   = 7,
  parameter int                  X_W           = 8,
  parameter int                  Y_W           = 7,
  parameter int                  COLOUR_W      = 3,
  parameter int                  X_MAX         = 159,
  parameter logic [COLOUR_W-1:0] SPRITE_COLOUR = 3'b111,
  parameter logic [COLOUR_W-1:0] BG_COLOUR     = 3'b000
) (
  input  logic                               clock,
  input  logic                               resetn,
  input  logic                               frame_tick,
  input  logic [$clog2(NUM_SPRITES+1)-1:0]   active_count,
  sprite_frame_engine_if.master              pix,
  output logic                               busy,
  output logic                               frame_done
`ifdef HIT_DETECT_EN
  ,
  input  logic                               shot_valid,
  input  logic [X_W-1:0]                     shot_x,
  input  logic [Y_W-1:0]                     shot_y,
  output logic [7:0]                         hit_count
`endif
);
  localparam int IW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
  localparam int CW = $clog2(NUM_SPRITES + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_SPRITES - 1);
  localparam logic [3:0]    LAST_PIX = 4'(BIRD_PIXELS - 1);

  state_t                 state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d, idx_nx;
  logic [3:0]             pix_q, pix_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [X_W-1:0]         xpos [NUM_SPRITES];
  logic [Y_W-1:0]         ypos [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] drawn_q;
  logic [NUM_SPRITES-1:0] alive;
  logic                   slot_act, slot_live, shot_hit;
  logic                   move_en, wrap_en, drawn_set, drawn_clr, slot_end;
  logic [2:0]             lfsr_next;
  offset_t                off;
  logic                   plotting;

  sprite_lfsr u_lfsr (
    .clock      (clock),
    .resetn     (resetn),
    .step       (wrap_en),
    .next_value (lfsr_next)
  );

  assign idx_nx    = idx_q + IW'(1);
  assign slot_act  = 32'(idx_q) < 32'(cnt_q);
  assign slot_live = slot_act && alive[idx_q];
  assign wrap_en   = move_en && (xpos[idx_q] == X_W'(X_MAX));
  assign busy      = (state_q != IDLE);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      idx_q   <= '0;
      pix_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pix_q   <= pix_d;
      cnt_q   <= cnt_d;
    end
  end

  // Slots with nothing on screen skip ERASE, and slots not being drawn leave MOVE straight to the next slot.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pix_d      = pix_q;
    cnt_d      = cnt_q;
    move_en    = 1'b0;
    drawn_set  = 1'b0;
    drawn_clr  = 1'b0;
    slot_end   = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_tick) begin
          cnt_d   = (active_count > CW'(NUM_SPRITES)) ? CW'(NUM_SPRITES) : active_count;
          idx_d   = '0;
          pix_d   = '0;
          state_d = drawn_q[0] ? ERASE : MOVE;
        end
      end
      ERASE: begin
        if (pix_q == LAST_PIX) begin
          pix_d   = '0;
          state_d = MOVE;
        end else begin
          pix_d = pix_q + 4'd1;
        end
      end
      MOVE: begin
        if (slot_live && !shot_hit) begin
          move_en = 1'b1;
          pix_d   = '0;
          state_d = DRAW;
        end else begin
          drawn_clr = 1'b1;
          slot_end  = 1'b1;
        end
      end
      DRAW: begin
        if (pix_q == LAST_PIX) begin
          drawn_set = 1'b1;
          slot_end  = 1'b1;
        end else begin
          pix_d = pix_q + 4'd1;
        end
      end
      DONE: begin
        frame_done = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (slot_end) begin
      pix_d = '0;
      if (idx_q == LAST_IDX) begin
        state_d = DONE;
      end else begin
        idx_d   = idx_nx;
        state_d = drawn_q[idx_nx] ? ERASE : MOVE;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int k = 0; k < NUM_SPRITES; k++) begin
        xpos[k] <= X_W'(WRAP_X + 20 * (k % 7));
        ypos[k] <= Y_W'(4 + 8 * (k % 8));
      end
      drawn_q <= '0;
    end else begin
      if (wrap_en) begin
        xpos[idx_q] <= X_W'(WRAP_X);
        ypos[idx_q] <= Y_W'({lfsr_next, 3'b100});
      end else if (move_en) begin
        xpos[idx_q] <= xpos[idx_q] + X_W'(1);
      end
      if (drawn_set) drawn_q[idx_q] <= 1'b1;
      if (drawn_clr) drawn_q[idx_q] <= 1'b0;
    end
  end

  always_comb begin
    off        = bird_offset(pix_q);
    plotting   = (state_q == ERASE) || (state_q == DRAW);
    pix.plot   = plotting;
    pix.colour = (state_q == DRAW) ? SPRITE_COLOUR : BG_COLOUR;
    pix.x_out  = '0;
    pix.y_out  = '0;
    if (plotting) begin
      pix.x_out = xpos[idx_q] + {{(X_W-4){off.dx[3]}}, off.dx};
      pix.y_out = ypos[idx_q] + {{(Y_W-4){off.dy[3]}}, off.dy};
    end
  end

`ifdef HIT_DETECT_EN
  logic                   shot_pend_q;
  logic [X_W-1:0]         shot_x_q;
  logic [Y_W-1:0]         shot_y_q;
  logic [NUM_SPRITES-1:0] alive_q;
  logic [7:0]             hit_q;
  logic                   hit_now;

  // Hit box spans the bird body (x-5..x) and wing span (y-3..y+3) at its pre-move position.
  assign shot_hit = shot_pend_q && slot_live
                 && (shot_x_q >= xpos[idx_q] - X_W'(5)) && (shot_x_q <= xpos[idx_q])
                 && (shot_y_q >= ypos[idx_q] - Y_W'(3)) && (shot_y_q <= ypos[idx_q] + Y_W'(3));
  assign hit_now   = (state_q == MOVE) && shot_hit;
  assign alive     = alive_q;
  assign hit_count = hit_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      shot_pend_q <= 1'b0;
      shot_x_q    <= '0;
      shot_y_q    <= '0;
      alive_q     <= '1;
      hit_q       <= '0;
    end else begin
      if (hit_now) begin
        alive_q[idx_q] <= 1'b0;
        if (hit_q != 8'hFF) hit_q <= hit_q + 8'd1;
      end
      if (shot_valid) begin
        shot_pend_q <= 1'b1;
        shot_x_q    <= shot_x;
        shot_y_q    <= shot_y;
      end else if (hit_now || state_q == DONE) begin
        shot_pend_q <= 1'b0;
      end
    end
  end
`else
  assign shot_hit = 1'b0;
  assign alive    = '1;
`endif

endmodule

// File: tb/tb_sprite_frame_engine.sv
// tb/tb_sprite_frame_engine.sv - directed and randomized frame checks of sprite_frame_engine against a frame-level model
module tb_sprite_frame_engine;
  localparam int NS = 7;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       frame_tick = 1'b0;
  logic [2:0] active_count = 3'd0;
  logic       busy, frame_done;
`ifdef HIT_DETECT_EN
  logic       shot_valid = 1'b0;
  logic [7:0] shot_x = 8'd0;
  logic [6:0] shot_y = 7'd0;
  logic [7:0] hit_count;
`endif

  sprite_frame_engine_if #(.X_W(8), .Y_W(7), .COLOUR_W(3)) pix_if ();

  sprite_frame_engine #(.NUM_SPRITES(NS)) dut (
    .clock        (clock),
    .resetn       (resetn),
    .frame_tick   (frame_tick),
    .active_count (active_count),
    .pix          (pix_if),
    .busy         (busy),
    .frame_done   (frame_done)
`ifdef HIT_DETECT_EN
    ,
    .shot_valid   (shot_valid),
    .shot_x       (shot_x),
    .shot_y       (shot_y),
    .hit_count    (hit_count)
`endif
  );

  always #10 clock = ~clock;

  int DX[13] = '{0, 0, -1, -2, -3, -4, -5, -3, -3, -4, -4, -5, -5};
  int DY[13] = '{0, 1, 0, 0, 0, 0, 0, 1, -1, 2, -2, 3, -3};

  int m_x[NS], m_y[NS];
  bit m_drawn[NS], m_alive[NS];
  int m_lfsr, m_hits, m_sx, m_sy;
  bit m_pend;
  int exp_q[$];
  int exp_busy;

  int n_checks = 0, n_pass = 0, n_fail = 0;
  int last_busy, first_draw, last_pix_n;

  function automatic int pk(input int x, input int y, input int c);
    return ((x & 255) << 16) | ((y & 127) << 8) | (c & 7);
  endfunction

  function automatic int lfsr_adv(input int s);
    int s2, s1, s0, n2, n1, n0;
    s2 = (s >> 2) & 1; s1 = (s >> 1) & 1; s0 = s & 1;
    n2 = s2 ^ s0; n1 = s1 ^ n2; n0 = s0 ^ n1;
    return n2 * 4 + n1 * 2 + n0;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_x[i] = 5 + 20 * (i % 7);
      m_y[i] = 4 + 8 * (i % 8);
      m_drawn[i] = 1'b0;
      m_alive[i] = 1'b1;
    end
    m_lfsr = 6; m_hits = 0; m_pend = 1'b0;
  endtask

  task automatic model_frame(input int cnt_in);
    int cnt;
    cnt = (cnt_in > NS) ? NS : cnt_in;
    exp_q.delete();
    for (int i = 0; i < NS; i++) begin
      if (m_drawn[i])
        for (int k = 0; k < 13; k++) exp_q.push_back(pk(m_x[i] + DX[k], m_y[i] + DY[k], 0));
      if (i < cnt && m_alive[i]) begin
        if (m_pend && m_sx >= m_x[i] - 5 && m_sx <= m_x[i] && m_sy >= m_y[i] - 3 && m_sy <= m_y[i] + 3) begin
          m_alive[i] = 1'b0;
          m_pend = 1'b0;
          if (m_hits < 255) m_hits++;
          m_drawn[i] = 1'b0;
        end else begin
          if (m_x[i] == 159) begin
            m_x[i] = 5;
            m_lfsr = lfsr_adv(m_lfsr);
            m_y[i] = 8 * m_lfsr + 4;
          end else begin
            m_x[i]++;
          end
          for (int k = 0; k < 13; k++) exp_q.push_back(pk(m_x[i] + DX[k], m_y[i] + DY[k], 7));
          m_drawn[i] = 1'b1;
        end
      end else begin
        m_drawn[i] = 1'b0;
      end
    end
    m_pend = 1'b0;
    exp_busy = NS + exp_q.size() + 1;
  endtask

  task automatic run_frame(input int cnt, input int stray_at, input string tag);
    int got_n, bad, busy_n, cyc, v, bad_got, bad_exp;
    bit done_seen;
    got_n = 0; bad = 0; busy_n = 0; cyc = 0; bad_got = 0; bad_exp = 0;
    done_seen = 1'b0; first_draw = -1;
    model_frame(cnt);
    active_count = 3'(cnt);
    @(posedge clock); #1 frame_tick = 1'b1;
    @(posedge clock); #1 frame_tick = 1'b0;
    while (!done_seen && cyc < 2000) begin
      @(negedge clock);
      cyc++;
      frame_tick = (cyc == stray_at);
      if (busy) busy_n++;
      if (pix_if.plot) begin
        v = pk(int'(pix_if.x_out), int'(pix_if.y_out), int'(pix_if.colour));
        if (pix_if.colour == 3'b111 && first_draw < 0) first_draw = v;
        if (got_n >= exp_q.size() || v != exp_q[got_n]) begin
          if (bad == 0) begin
            bad_got = v;
            bad_exp = (got_n < exp_q.size()) ? exp_q[got_n] : -1;
          end
          bad++;
        end
        got_n++;
      end
      if (frame_done) done_seen = 1'b1;
    end
    frame_tick = 1'b0;
    last_busy = busy_n;
    last_pix_n = got_n;
    check({tag, " frame_done seen"}, int'(done_seen), 1);
    check({tag, " pixel count"}, got_n, exp_q.size());
    check($sformatf("%s pixel stream (first diff got %h want %h)", tag, bad_got, bad_exp), bad, 0);
    check({tag, " busy cycles"}, busy_n, exp_busy);
    @(negedge clock);
    check({tag, " idle after done"}, int'({busy, frame_done, pix_if.plot}), 0);
`ifdef HIT_DETECT_EN
    check({tag, " hit_count"}, int'(hit_count), m_hits);
`endif
  endtask

`ifdef HIT_DETECT_EN
  task automatic fire_shot(input int sx, input int sy);
    @(posedge clock); #1;
    shot_valid = 1'b1; shot_x = 8'(sx); shot_y = 7'(sy);
    m_pend = 1'b1; m_sx = sx & 255; m_sy = sy & 127;
    @(posedge clock); #1 shot_valid = 1'b0;
  endtask
`endif

  task automatic reset_dut();
    @(negedge clock) resetn = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock) resetn = 1'b1;
  endtask

  initial begin
    int cnt, stray, s;
    model_reset();
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("in reset outputs", int'({pix_if.plot, busy, frame_done, pix_if.colour, pix_if.x_out, pix_if.y_out}), 0);
    resetn = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      check("idle outputs", int'({pix_if.plot, busy, frame_done, pix_if.colour, pix_if.x_out, pix_if.y_out}), 0);
    end
`ifdef HIT_DETECT_EN
    check("reset hit_count", int'(hit_count), 0);
`endif

    run_frame(1, 0, "frame1");
    check("frame1 busy length", last_busy, 21);
    check("frame1 first draw", first_draw, pk(6, 4, 7));
    run_frame(1, 0, "frame2");
    check("frame2 busy length", last_busy, 34);
    check("frame2 first draw", first_draw, pk(7, 4, 7));
    for (int f = 0; f < 152; f++) run_frame(1, 0, "walk");
    run_frame(1, 0, "wrap1");
    check("wrap1 respawn", first_draw, pk(5, 36, 7));
    for (int f = 0; f < 154; f++) run_frame(1, 0, "walk2");
    run_frame(1, 0, "wrap2");
    check("wrap2 respawn", first_draw, pk(5, 60, 7));

    run_frame(3, 0, "cnt3a");
    run_frame(3, 0, "cnt3b");
    run_frame(1, 10, "shrink");
    check("shrink busy length", last_busy, 60);
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      check("stray tick dropped", int'(busy), 0);
    end

    for (int f = 0; f < 40; f++) begin
      cnt = $urandom_range(0, 7);
      stray = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 15)) : 0;
`ifdef HIT_DETECT_EN
      if ($urandom_range(0, 1) == 1) begin
        s = $urandom_range(0, NS - 1);
        fire_shot(m_x[s] - int'($urandom_range(0, 6)), m_y[s] + int'($urandom_range(0, 8)) - 4);
      end
`else
      s = 0;
`endif
      run_frame(cnt, stray, $sformatf("rand%0d", f));
    end

    active_count = 3'd7;
    @(posedge clock); #1 frame_tick = 1'b1;
    @(posedge clock); #1 frame_tick = 1'b0;
    repeat (30) @(negedge clock);
    resetn = 1'b0;
    #1;
    check("mid-frame reset outputs", int'({pix_if.plot, busy, frame_done, pix_if.x_out}), 0);
    model_reset();
    @(negedge clock) resetn = 1'b1;
    run_frame(7, 0, "post reset");

`ifdef HIT_DETECT_EN
    reset_dut();
    run_frame(1, 0, "hit pre1");
    run_frame(1, 0, "hit pre2");
    fire_shot(7, 4);
    run_frame(1, 0, "hit");
    check("hit count after kill", int'(hit_count), 1);
    check("hit frame erase only", last_pix_n, 13);
    run_frame(1, 0, "dead");
    check("dead slot pixels", last_pix_n, 0);
    fire_shot(0, 100);
    run_frame(1, 0, "miss");
    check("miss hit_count", int'(hit_count), 1);
`else
    reset_dut();
    run_frame(2, 0, "after reset");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
